// File: rtl/sram_responder_if.sv
// Request/response bundle between the SRAM arbiter (master) and the memory-side responder (slave).
// Handshake: a request transfers on a clock edge where sram_addr_valid and sram_ready are both high.
interface sram_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic                  sram_addr_valid;
    logic                  sram_ready;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic [MASK_WIDTH-1:0] sram_write_mask;
    logic [DATA_WIDTH-1:0] sram_data_out;
    logic                  sram_data_out_valid;

    modport master (
        output sram_addr_valid,
        output sram_addr,
        output sram_data_in,
        output sram_write_mask,
        input  sram_ready,
        input  sram_data_out,
        input  sram_data_out_valid
    );

    modport slave (
        input  sram_addr_valid,
        input  sram_addr,
        input  sram_data_in,
        input  sram_write_mask,
        output sram_ready,
        output sram_data_out,
        output sram_data_out_valid
    );
endinterface

// File: rtl/sram_responder.sv
// Byte-masked SRAM model behind the arbiter port; read data valid READ_LATENCY edges after acceptance.
// Backpressure: sram_ready drops for REFRESH_CYCLES every REFRESH_PERIOD ready cycles; refused requests are not queued.
module sram_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic            sram_clock,
    input  logic            reset,
    sram_responder_if.slave bus
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [0:0] {
        RUN,
        REFRESH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rdy;
    logic             rdy_nxt;

    logic acc_vld;
    logic wr_vld;
    logic rd_vld;

    logic [DATA_WIDTH-1:0]   mem      [DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   out_dat;
    logic                    out_vld;

    // Requests seen while reset is asserted are dropped even if ready was still high.
    assign acc_vld = bus.sram_addr_valid && rdy && !reset;
    assign wr_vld  = acc_vld && (bus.sram_write_mask != '0);
    assign rd_vld  = acc_vld && (bus.sram_write_mask == '0);

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            rdy   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rdy   <= rdy_nxt;
        end
    end

    // A RUN state with ready low only occurs on the first edge out of reset; it opens the first ready window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        rdy_nxt   = rdy;
        case (state)
            RUN: begin
                if (!rdy) begin
                    rdy_nxt = 1'b1;
                    cnt_nxt = '0;
                end else if ((REFRESH_PERIOD != 0) && (cnt == RUN_LAST)) begin
                    state_nxt = REFRESH;
                    rdy_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            REFRESH: begin
                if (cnt == REF_LAST) begin
                    state_nxt = RUN;
                    rdy_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                rdy_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage and the data half of the read pipeline carry no reset so the array maps onto block RAM.
    always_ff @(posedge sram_clock) begin
        for (int b = 0; b < MASK_WIDTH; b++) begin
            if (wr_vld && bus.sram_write_mask[b]) begin
                mem[bus.sram_addr][8*b +: 8] <= bus.sram_data_in[8*b +: 8];
            end
        end
        if (rd_vld) begin
            pipe_dat[0] <= mem[bus.sram_addr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_vld;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            out_dat <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= pipe_vld[READ_LATENCY-1];
            if (pipe_vld[READ_LATENCY-1]) begin
                out_dat <= pipe_dat[READ_LATENCY-1];
            end
        end
    end

    assign bus.sram_ready          = rdy;
    assign bus.sram_data_out       = out_dat;
    assign bus.sram_data_out_valid = out_vld;
endmodule

// File: tb/tb_sram_responder.sv
// Two responders side by side: one never refreshes, one refreshes 8 on / 2 off; a scoreboard checks both.
module tb_sram_responder;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int MW  = 4;
    localparam int LAT = 2;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rst_nxt = 1'b1;

    logic          avld [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic [MW-1:0] mask [2];
    logic          rdy  [2];
    logic [DW-1:0] dout [2];
    logic          dvld [2];

    sram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    sram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.sram_addr_valid = avld[0];
    assign bus_a.sram_addr       = addr[0];
    assign bus_a.sram_data_in    = din[0];
    assign bus_a.sram_write_mask = mask[0];
    assign rdy[0]                = bus_a.sram_ready;
    assign dout[0]               = bus_a.sram_data_out;
    assign dvld[0]               = bus_a.sram_data_out_valid;

    assign bus_b.sram_addr_valid = avld[1];
    assign bus_b.sram_addr       = addr[1];
    assign bus_b.sram_data_in    = din[1];
    assign bus_b.sram_write_mask = mask[1];
    assign rdy[1]                = bus_b.sram_ready;
    assign dout[1]               = bus_b.sram_data_out;
    assign dvld[1]               = bus_b.sram_data_out_valid;

    sram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
        .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) dut_a (
        .sram_clock(clk),
        .reset     (rst),
        .bus       (bus_a.slave)
    );

    sram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
        .REFRESH_PERIOD(8), .REFRESH_CYCLES(2)
    ) dut_b (
        .sram_clock(clk),
        .reset     (rst),
        .bus       (bus_b.slave)
    );

    int cyc     = 0;
    int run_cnt = -1;
    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] mem_m [2][1 << AW];
    req_t          stim_q [2][$];
    exp_t          exp_q  [2][$];
    req_t          cur    [2];
    logic          acc    [2];

    function automatic logic [AW-1:0] pool(int k);
        return (k == 31) ? {AW{1'b1}} : AW'(k);
    endfunction

    function automatic void push(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        req_t r;
        r.vld  = 1'b1;
        r.addr = a;
        r.data = d;
        r.mask = m;
        stim_q[i].push_back(r);
    endfunction

    function automatic void push_idle(int i);
        req_t r;
        r.vld  = 1'b0;
        r.addr = AW'($urandom);
        r.data = $urandom;
        r.mask = MW'($urandom);
        stim_q[i].push_back(r);
    endfunction

    // Reference: a read returns the array word as it stood at acceptance, LAT edges later.
    function automatic void model_accept(int i, req_t r);
        exp_t e;
        if (r.mask == '0) begin
            e.data = mem_m[i][r.addr];
            e.due  = cyc + 1 + LAT;
            exp_q[i].push_back(e);
        end else begin
            for (int b = 0; b < MW; b++) begin
                if (r.mask[b]) mem_m[i][r.addr][8*b +: 8] = r.data[8*b +: 8];
            end
        end
    endfunction

    // Inputs change on the falling edge; ready is stable until the next rising edge, so acceptance is known here.
    task automatic step();
        @(negedge clk);
        rst = rst_nxt;
        for (int i = 0; i < 2; i++) begin
            if (acc[i] || !cur[i].vld) begin
                if (stim_q[i].size() > 0) begin
                    cur[i] = stim_q[i].pop_front();
                end else begin
                    cur[i].vld = 1'b0;
                end
            end
            avld[i] = cur[i].vld;
            addr[i] = cur[i].addr;
            din[i]  = cur[i].data;
            mask[i] = cur[i].mask;
            acc[i]  = cur[i].vld && (rdy[i] === 1'b1) && !rst_nxt;
            if (acc[i]) model_accept(i, cur[i]);
        end
    endtask

    function automatic logic busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (stim_q[i].size() > 0 || exp_q[i].size() > 0 || (cur[i].vld && !acc[i])) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 4000) begin
            step();
            n++;
        end
        repeat (4) step();
        vectors++;
        if (busy()) begin
            errors++;
            $display("FAIL drain: traffic still pending after %0d cycles, required none", n);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            run_cnt = -1;
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            run_cnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic er;
            exp_t e;
            er = (run_cnt < 0) ? 1'b0 : ((i == 0) ? 1'b1 : ((run_cnt % 10) < 8));
            vectors++;
            if (rdy[i] !== er) begin
                errors++;
                $display("FAIL ready[%0d] cyc %0d: got %b required %b", i, cyc, rdy[i], er);
            end
            if (run_cnt < 0) begin
                vectors++;
                if (dvld[i] !== 1'b0 || dout[i] !== '0) begin
                    errors++;
                    $display("FAIL reset_out[%0d] cyc %0d: valid %b data %h required 0/0", i, cyc, dvld[i], dout[i]);
                end
            end else if (dvld[i] === 1'b1) begin
                vectors++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid[%0d] cyc %0d: data %h with no read outstanding", i, cyc, dout[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (dout[i] !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL read[%0d]: got %h at cyc %0d, required %h at cyc %0d", i, dout[i], cyc, e.data, e.due);
                    end
                end
            end else if (dvld[i] !== 1'b0) begin
                vectors++;
                errors++;
                $display("FAIL valid_x[%0d] cyc %0d: got %b required 0 or 1", i, cyc, dvld[i]);
            end else if (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) begin
                e = exp_q[i].pop_front();
                vectors++;
                errors++;
                $display("FAIL missing_read[%0d]: no valid by cyc %0d, required %h at cyc %0d", i, cyc, e.data, e.due);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            avld[i]    = 1'b0;
            addr[i]    = '0;
            din[i]     = '0;
            mask[i]    = '0;
            cur[i].vld = 1'b0;
            acc[i]     = 1'b0;
        end

        rst_nxt = 1'b1;
        repeat (3) step();
        rst_nxt = 1'b0;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 32; k++) push(i, pool(k), $urandom, 4'hF);
            push(i, 10'd5, 32'hDEADBEEF, 4'hF);
            push(i, 10'd5, 32'h0, 4'h0);
            push(i, 10'd7, 32'h11223344, 4'hF);
            push(i, 10'd7, 32'hAABBCCDD, 4'h5);
            push(i, 10'd7, 32'h0, 4'h0);
            for (int k = 0; k < 4; k++) push(i, AW'(k), 32'h10 + 32'(k), 4'hF);
            for (int k = 0; k < 4; k++) push(i, AW'(k), 32'h0, 4'h0);
            push(i, 10'd9, 32'h1, 4'hF);
            push(i, 10'd9, 32'h0, 4'h0);
        end
        drain();

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    push_idle(i);
                end else begin
                    push(i, pool(int'($urandom_range(0, 31))), $urandom,
                         ($urandom_range(0, 1) == 1) ? MW'($urandom) : '0);
                end
            end
        end
        drain();

        // Reset lands one edge after a read is accepted; that read must never come back.
        push(0, 10'd5, 32'h0, 4'h0);
        n = 0;
        while (!acc[0] && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (!acc[0]) begin
            errors++;
            $display("FAIL midflight_accept: read not accepted within %0d cycles", n);
        end
        rst_nxt = 1'b1;
        repeat (3) step();
        rst_nxt = 1'b0;

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 32; k++) push(i, pool(k), 32'h0, 4'h0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
